// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   ROWS/COLS     : matrix geometry
//   KEY_*         : one-hot key codes as decoded by onehot2binary (bit = row*4 + col)
//   scan_state_t  : column scan states
//   popcount16    : number of set bits in a 16-bit frame
package keypad_scan_pkg;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;

    localparam logic [15:0] KEY_NONE  = 16'h0000;
    localparam logic [15:0] KEY_ENTER = 16'h0001;
    localparam logic [15:0] KEY_0     = 16'h0008;
    localparam logic [15:0] KEY_CLR   = 16'h0100;
    localparam logic [15:0] KEY_BACK  = 16'h1000;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } scan_state_t;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            n = n + {4'b0000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/keypad_scan_debounce.sv
// Frame debouncer for the keypad scanner.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_frame_done   : 1-cycle pulse, i_frame holds a complete raw frame
//   i_frame        : raw pressed-key snapshot (bit = row*4 + col)
//   o_onehot       : committed key, 0 when none or more than one key pressed
//   o_key_valid    : 1-cycle pulse when o_onehot changes to a new nonzero value
module keypad_debounce
    import keypad_scan_pkg::*;
#(
    parameter int unsigned DEB_FRAMES = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_done,
    input  logic [15:0] i_frame,
    output logic [15:0] o_onehot,
    output logic        o_key_valid
);

    localparam int unsigned     CW      = $clog2(DEB_FRAMES + 1);
    localparam logic [CW-1:0]   DEB_MAX = CW'(DEB_FRAMES);

    logic [15:0]   r_last_frame;
    logic [CW-1:0] r_stable_cnt;
    logic          r_check;
    logic [15:0]   r_onehot;
    logic          r_key_valid;

    logic [4:0]    w_pop;
    logic          w_commit;
    logic [15:0]   w_commit_val;

    // Commit is evaluated the cycle after a frame, once the counter has absorbed it.
    always_comb begin
        w_pop        = popcount16(r_last_frame);
        w_commit     = r_check && (r_stable_cnt == DEB_MAX);
        w_commit_val = (w_pop == 5'd1) ? r_last_frame : KEY_NONE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_frame <= '0;
            r_stable_cnt <= '0;
            r_check      <= 1'b0;
            r_onehot     <= '0;
            r_key_valid  <= 1'b0;
        end else begin
            r_check     <= i_frame_done;
            r_key_valid <= 1'b0;
            if (i_frame_done) begin
                if (i_frame == r_last_frame) begin
                    if (r_stable_cnt != DEB_MAX) begin
                        r_stable_cnt <= r_stable_cnt + CW'(1);
                    end
                end else begin
                    r_last_frame <= i_frame;
                    r_stable_cnt <= CW'(1);
                end
            end
            if (w_commit) begin
                r_onehot    <= w_commit_val;
                r_key_valid <= (w_commit_val != KEY_NONE) && (w_commit_val != r_onehot);
            end
        end
    end

    assign o_onehot    = r_onehot;
    assign o_key_valid = r_key_valid;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one column low at a time, samples the
// synchronised pulled-up rows at the end of each column dwell, assembles a
// 16-bit frame and hands it to the debouncer.
//   clk, rst_n : clock, asynchronous active-low reset
//   row_in     : keypad rows (asynchronous, 0 = closed on driven column)
//   col_out    : keypad columns, exactly one low
//   onehot     : debounced key (bit = row*4 + col), 0 = none/invalid
//   key_valid  : 1-cycle pulse on a new nonzero onehot
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned SCAN_HZ    = 1_000,
    parameter int unsigned DEB_FRAMES = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] onehot,
    output logic        key_valid
);

    localparam int unsigned   TICK_DIV  = CLK_HZ / SCAN_HZ;
    localparam int unsigned   TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [TW-1:0] r_tick_cnt;
    scan_state_t   r_state;
    scan_state_t   w_state_next;
    logic [15:0]   r_raw;
    logic          r_frame_done;

    logic          w_tick;
    logic [3:0]    w_pressed;
    logic [3:0]    w_col_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= row_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = ~r_sync2;
    assign w_tick    = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COL0;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Column drive is decoded from the state register, so the next column goes
    // low on the same edge that samples the current one.
    always_comb begin
        w_state_next = r_state;
        w_col_n      = 4'b1110;
        unique case (r_state)
            COL0: begin
                w_col_n = 4'b1110;
                if (w_tick) w_state_next = COL1;
            end
            COL1: begin
                w_col_n = 4'b1101;
                if (w_tick) w_state_next = COL2;
            end
            COL2: begin
                w_col_n = 4'b1011;
                if (w_tick) w_state_next = COL3;
            end
            COL3: begin
                w_col_n = 4'b0111;
                if (w_tick) w_state_next = COL0;
            end
            default: begin
                w_col_n      = 4'b1110;
                w_state_next = COL0;
            end
        endcase
    end

    assign col_out = w_col_n;

    // Bit index row*4 + col is the concatenation {row, col}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_tick && (r_state == COL3);
            if (w_tick) begin
                for (int unsigned r = 0; r < ROWS; r++) begin
                    r_raw[{r[1:0], r_state}] <= w_pressed[r];
                end
            end
        end
    end

    keypad_debounce #(
        .DEB_FRAMES(DEB_FRAMES)
    ) u_debounce (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_frame_done (r_frame_done),
        .i_frame      (r_raw),
        .o_onehot     (onehot),
        .o_key_valid  (key_valid)
    );

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan with CLK_HZ=1000, SCAN_HZ=100 (10 clk per
// column, 40 clk per frame) and DEB_FRAMES=3. A keypad model pulls row r low
// when column c is driven low and key (r,c) is closed.
module tb_keypad_scan;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] onehot;
    logic        key_valid;
    logic [15:0] keys = '0;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    keypad_scan #(
        .CLK_HZ     (1000),
        .SCAN_HZ    (100),
        .DEB_FRAMES (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .onehot    (onehot),
        .key_valid (key_valid)
    );

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: columns step every 10 clk since reset; each column sample
    // sees the key matrix as it was two edges earlier (synchroniser); after every
    // full frame, if the last three frames since reset are identical the value
    // (or 0 if not exactly one key) is committed two clocks later.
    int unsigned  m_e       = 0;
    logic [15:0]  m_k1      = '0;
    logic [15:0]  m_k2      = '0;
    logic [15:0]  m_frame   = '0;
    logic [15:0]  m_onehot  = '0;
    logic         m_kv      = 1'b0;
    logic [15:0]  m_frames[$];
    int           m_pend    = 0;
    logic [15:0]  m_pend_val = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_e = 0; m_k1 = '0; m_k2 = '0; m_frame = '0;
            m_onehot = '0; m_kv = 1'b0; m_frames.delete(); m_pend = 0;
        end else begin
            int col;
            m_kv = 1'b0;
            if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) begin
                    if (m_pend_val != 16'h0 && m_pend_val != m_onehot) m_kv = 1'b1;
                    m_onehot = m_pend_val;
                end
            end
            if (m_e % 10 == 9) begin
                col = (m_e / 10) % 4;
                for (int r = 0; r < 4; r++) m_frame[r*4 + col] = m_k2[r*4 + col];
                if (col == 3) begin
                    m_frames.push_back(m_frame);
                    if (m_frames.size() > 3) void'(m_frames.pop_front());
                    if (m_frames.size() == 3 && m_frames[0] == m_frames[1] && m_frames[1] == m_frames[2]) begin
                        m_pend     = 2;
                        m_pend_val = ($countones(m_frame) == 1) ? m_frame : 16'h0;
                    end
                end
            end
            m_k2 = m_k1;
            m_k1 = keys;
            m_e++;
        end
    end

    always @(negedge clk) begin
        logic [3:0] exp_col;
        exp_col = ~(4'b0001 << ((m_e / 10) % 4));
        check("col_out", {28'h0, col_out}, {28'h0, exp_col});
        check("onehot", {16'h0, onehot}, {16'h0, m_onehot});
        check("key_valid", {31'h0, key_valid}, {31'h0, m_kv});
    end

    int unsigned kv_count = 0;
    logic        watch_zero = 1'b0;
    logic        saw_zero   = 1'b0;

    always @(negedge clk) begin
        if (key_valid === 1'b1) kv_count++;
        if (watch_zero && onehot == 16'h0) saw_zero = 1'b1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int unsigned kv0;
        logic [3:0] col_seq [4];
        col_seq[0] = 4'b1101; col_seq[1] = 4'b1011; col_seq[2] = 4'b0111; col_seq[3] = 4'b1110;

        wait_clk(3);
        check("reset_col", {28'h0, col_out}, 32'h0000_000e);
        check("reset_onehot", {16'h0, onehot}, 32'h0);
        check("reset_kv", {31'h0, key_valid}, 32'h0);
        rst_n = 1'b1;

        // 1: idle scanning
        kv0 = kv_count;
        for (int i = 0; i < 4; i++) begin
            wait_clk(10);
            check("s1_col_step", {28'h0, col_out}, {28'h0, col_seq[i]});
        end
        wait_clk(19 * 40);
        check("s1_onehot", {16'h0, onehot}, 32'h0);
        check("s1_kv_pulses", kv_count - kv0, 32'd0);

        // 2: press and release key(0,3)
        kv0 = kv_count;
        keys = 16'h0008;
        wait_clk(4 * 40 + 3);
        check("s2_press", {16'h0, onehot}, 32'h0000_0008);
        wait_clk(80);
        check("s2_kv_pulses", kv_count - kv0, 32'd1);
        kv0 = kv_count;
        keys = 16'h0000;
        wait_clk(4 * 40 + 3);
        check("s2_release", {16'h0, onehot}, 32'h0);
        check("s2_release_kv", kv_count - kv0, 32'd0);

        // 3: bounce key(2,0) every frame, then hold
        kv0 = kv_count;
        for (int i = 0; i < 10; i++) begin
            keys = keys ^ 16'h0100;
            wait_clk(40);
        end
        check("s3_bounce_onehot", {16'h0, onehot}, 32'h0);
        check("s3_bounce_kv", kv_count - kv0, 32'd0);
        keys = 16'h0100;
        wait_clk(4 * 40 + 3);
        check("s3_hold", {16'h0, onehot}, 32'h0000_0100);
        check("s3_kv_pulses", kv_count - kv0, 32'd1);
        keys = 16'h0000;
        wait_clk(200);

        // 4: multi-key rejection and recovery
        kv0 = kv_count;
        keys = 16'h0001;
        wait_clk(200);
        check("s4_a", {16'h0, onehot}, 32'h0000_0001);
        keys = 16'h0021;
        wait_clk(200);
        check("s4_multi", {16'h0, onehot}, 32'h0);
        keys = 16'h0020;
        wait_clk(200);
        check("s4_b", {16'h0, onehot}, 32'h0000_0020);
        check("s4_kv_pulses", kv_count - kv0, 32'd2);
        keys = 16'h0000;
        wait_clk(200);

        // 5: asynchronous reset mid-frame with key(3,3) held
        keys = 16'h8000;
        wait_clk(200);
        check("s5_pre_reset", {16'h0, onehot}, 32'h0000_8000);
        wait_clk(13);
        #2 rst_n = 1'b0;
        #1;
        check("s5_async_onehot", {16'h0, onehot}, 32'h0);
        check("s5_async_col", {28'h0, col_out}, 32'h0000_000e);
        check("s5_async_kv", {31'h0, key_valid}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        kv0 = kv_count;
        wait_clk(200);
        check("s5_post_reset", {16'h0, onehot}, 32'h0000_8000);
        check("s5_kv_pulses", kv_count - kv0, 32'd1);
        keys = 16'h0000;
        wait_clk(200);

        // 6: direct swap key(1,2) -> key(1,1) on a frame boundary
        kv0 = kv_count;
        keys = 16'h0040;
        wait_clk(200);
        check("s6_first", {16'h0, onehot}, 32'h0000_0040);
        while (m_e % 40 != 0) wait_clk(1);
        saw_zero   = 1'b0;
        watch_zero = 1'b1;
        keys = 16'h0020;
        wait_clk(200);
        watch_zero = 1'b0;
        check("s6_second", {16'h0, onehot}, 32'h0000_0020);
        check("s6_no_zero", {31'h0, saw_zero}, 32'h0);
        check("s6_kv_pulses", kv_count - kv0, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
